// File: rtl/rs232out_pkg.sv
// Definitions shared by the RS-232 receiver and transmitter: default line
// parameters, bit-period formula, bit-timer width and transmitter FSM states.
package rs232out_pkg;

  localparam int unsigned DefaultBps       = 115_200;
  localparam int unsigned DefaultFrequency = 25_000_000;
  localparam int unsigned TimerWidth       = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  // Bit time minus one, in clocks; both directions must agree on it.
  function automatic int unsigned bitPeriod(input int unsigned freq, input int unsigned rate);
    return freq / rate - 1;
  endfunction

endpackage

// File: rtl/rs232out_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty come from the
// count held at the start of the cycle, so a write while full is always dropped.
module sync_fifo #(
  parameter int width      = 8,
  parameter int log2_depth = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_i,
  input  logic [width-1:0]      wdata_i,
  input  logic                  rd_i,
  output logic [width-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [log2_depth:0]   count_o
);

  localparam int Depth = 1 << log2_depth;
  localparam logic [log2_depth-1:0] PtrOne   = 1;
  localparam logic [log2_depth:0]   CountOne = 1;
  localparam logic [log2_depth:0]   CountMax = Depth;

  logic [width-1:0]      mem_q [Depth];
  logic [log2_depth-1:0] wrPtr_q, rdPtr_q;
  logic [log2_depth:0]   count_q;
  logic                  doWrite, doRead;

  assign full_o  = (count_q == CountMax);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doWrite = wr_i && !full_o;
  assign doRead  = rd_i && !empty_o;

  // Storage is not reset; reset only empties the FIFO through the pointers.
  always_ff @(posedge clk_i) begin
    if (doWrite) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + PtrOne;
      if (doRead)  rdPtr_q <= rdPtr_q + PtrOne;
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rs232out.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB
// first, back to back with no idle gap while the FIFO has data.
module rs232out
  import rs232out_pkg::*;
#(
  parameter int unsigned bps        = DefaultBps,
  parameter int unsigned frequency  = DefaultFrequency,
  parameter int unsigned period     = bitPeriod(frequency, bps),
  parameter int unsigned log2_depth = 4
) (
  input  logic       clk25MHz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       write,
  output logic       full,
  output logic       overflow,
  output logic       idle,
  output logic       serial_txd
);

  localparam logic [TimerWidth-1:0] PeriodT  = TimerWidth'(period);
  localparam logic [TimerWidth-1:0] TimerOne = 1;

  txState_e              state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [2:0]            bitCnt_q, bitCnt_d;
  logic [7:0]            sh_q, sh_d;
  logic                  txd_q, txd_d;
  logic                  overflow_q;

  logic                  pop;
  logic [7:0]            fifoData;
  logic                  fifoFull, fifoEmpty;
  logic [log2_depth:0]   fifoCount;

  sync_fifo #(
    .width      (8),
    .log2_depth (log2_depth)
  ) u_fifo (
    .clk_i   (clk25MHz),
    .reset_i (reset),
    .wr_i    (write),
    .wdata_i (data),
    .rd_i    (pop),
    .rdata_o (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Every line level is held for period+1 clocks: loaded with period, changed when it hits zero.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitCnt_d = bitCnt_q;
    sh_d     = sh_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    if (timer_q != '0) timer_d = timer_q - TimerOne;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          sh_d    = fifoData;
          txd_d   = 1'b0;
          timer_d = PeriodT;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          txd_d    = sh_q[0];
          sh_d     = {1'b0, sh_q[7:1]};
          bitCnt_d = 3'd7;
          timer_d  = PeriodT;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = PeriodT;
          if (bitCnt_q != 3'd0) begin
            txd_d    = sh_q[0];
            sh_d     = {1'b0, sh_q[7:1]};
            bitCnt_d = bitCnt_q - 3'd1;
          end else begin
            txd_d   = 1'b1;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (!fifoEmpty) begin
            pop     = 1'b1;
            sh_d    = fifoData;
            txd_d   = 1'b0;
            timer_d = PeriodT;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitCnt_q   <= '0;
      sh_q       <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitCnt_q   <= bitCnt_d;
      sh_q       <= sh_d;
      txd_q      <= txd_d;
      overflow_q <= write && fifoFull;
    end
  end

  assign serial_txd = txd_q;
  assign full       = fifoFull;
  assign overflow   = overflow_q;
  assign idle       = (state_q == IDLE) && (fifoCount == '0);

endmodule

// File: tb/tb_rs232out.sv
// Bench for rs232out: a frame-schedule model predicts the line, full, overflow
// and idle every cycle, and a sampling receiver decodes the bytes sent.
module tb_rs232out;

  localparam int BitClocks   = 217;
  localparam int FrameClocks = 10 * BitClocks;
  localparam int Depth       = 16;

  logic       clk25MHz = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       write;
  logic       full, overflow, idle, serial_txd;

  rs232out dut (
    .clk25MHz   (clk25MHz),
    .reset      (reset),
    .data       (data),
    .write      (write),
    .full       (full),
    .overflow   (overflow),
    .idle       (idle),
    .serial_txd (serial_txd)
  );

  always #20 clk25MHz = ~clk25MHz;

  // Number of the most recent rising edge.
  int cyc;
  always @(posedge clk25MHz) cyc <= cyc + 1;

  int         acceptQ[$];
  int         startQ[$];
  logic [7:0] byteQ[$];
  logic [7:0] rxExpQ[$];
  logic [7:0] rxGotQ[$];
  int         lastStart;
  int         lastDrop;
  int         checkCount;
  int         passCount;
  int         failCount;
  bit         checkEn;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Bytes held in the FIFO after edge c: accepted minus popped by then.
  function automatic int countAt(input int c);
    int n;
    n = 0;
    foreach (acceptQ[i]) if (acceptQ[i] <= c) n++;
    foreach (startQ[i]) if (startQ[i] <= c) n--;
    return n;
  endfunction

  function automatic bit frameBusy(input int c);
    bit busy;
    busy = 1'b0;
    foreach (startQ[i]) if (c >= startQ[i] && c < startQ[i] + FrameClocks) busy = 1'b1;
    return busy;
  endfunction

  function automatic logic expLine(input int c);
    logic level;
    int   bitIdx;
    level = 1'b1;
    foreach (startQ[i]) begin
      if (c >= startQ[i] && c < startQ[i] + FrameClocks) begin
        bitIdx = (c - startQ[i]) / BitClocks;
        if (bitIdx == 0) level = 1'b0;
        else if (bitIdx <= 8) level = byteQ[i][bitIdx-1];
      end
    end
    return level;
  endfunction

  // A byte accepted at edge t starts one clock later, or when the previous frame ends.
  task automatic modelWrite(input int t, input logic [7:0] b);
    int s;
    if (countAt(t - 1) < Depth) begin
      s = (t + 1 > lastStart + FrameClocks) ? t + 1 : lastStart + FrameClocks;
      acceptQ.push_back(t);
      startQ.push_back(s);
      byteQ.push_back(b);
      rxExpQ.push_back(b);
      lastStart = s;
    end else begin
      lastDrop = t;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    modelWrite(cyc + 1, b);
    data  = b;
    write = 1'b1;
    @(negedge clk25MHz);
    write = 1'b0;
  endtask

  task automatic waitDrain();
    repeat (lastStart + FrameClocks - cyc + 10) @(negedge clk25MHz);
    acceptQ.delete();
    startQ.delete();
    byteQ.delete();
  endtask

  task automatic checkRx(input string tag);
    checkOutput({tag, " frame count"}, rxGotQ.size(), rxExpQ.size());
    for (int i = 0; i < rxExpQ.size() && i < rxGotQ.size(); i++)
      checkOutput({tag, " byte"}, int'(rxGotQ[i]), int'(rxExpQ[i]));
    rxGotQ.delete();
    rxExpQ.delete();
  endtask

  always @(negedge clk25MHz) begin
    int n;
    if (checkEn) begin
      n = countAt(cyc);
      checkOutput("serial_txd", int'(serial_txd), int'(expLine(cyc)));
      checkOutput("full", int'(full), int'(n == Depth));
      checkOutput("overflow", int'(overflow), int'(lastDrop == cyc));
      checkOutput("idle", int'(idle), int'(n == 0 && !frameBusy(cyc)));
    end
  end

  // Independent receiver: detect start bit, sample each bit near its middle.
  bit         rxBusy;
  int         rxCnt;
  logic [7:0] rxShift;
  always @(negedge clk25MHz) begin
    if (reset) begin
      rxBusy <= 1'b0;
    end else if (!rxBusy) begin
      if (serial_txd == 1'b0) begin
        rxBusy <= 1'b1;
        rxCnt  <= 1;
      end
    end else begin
      rxCnt <= rxCnt + 1;
      if (rxCnt % BitClocks == BitClocks / 2 && rxCnt / BitClocks >= 1 && rxCnt / BitClocks <= 8)
        rxShift <= {serial_txd, rxShift[7:1]};
      if (rxCnt == 9 * BitClocks + BitClocks / 2) begin
        rxBusy <= 1'b0;
        if (serial_txd == 1'b1) rxGotQ.push_back(rxShift);
      end
    end
  end

  initial begin
    int         e1;
    int         gap;
    logic [7:0] r0, r1;
    reset     = 1'b1;
    write     = 1'b0;
    data      = 8'h00;
    lastStart = -100000;
    lastDrop  = -1;
    repeat (3) @(negedge clk25MHz);
    checkOutput("reset serial_txd", int'(serial_txd), 1);
    checkOutput("reset full", int'(full), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    checkOutput("reset idle", int'(idle), 1);
    reset   = 1'b0;
    checkEn = 1'b1;
    repeat (5) @(negedge clk25MHz);

    $display("[TB] single byte 0x55");
    applyStimulus(8'h55);
    waitDrain();
    checkRx("single");

    $display("[TB] burst 0x41 0x42 0x43");
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    waitDrain();
    checkRx("burst");

    $display("[TB] loopback 0x00 0xFF 0xA5");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'hA5);
    waitDrain();
    checkRx("loopback");

    $display("[TB] overflow burst, then write while full on the first pop cycle");
    e1 = cyc + 1;
    for (int i = 0; i < 18; i++) applyStimulus(8'(i));
    repeat (e1 + FrameClocks - cyc) @(negedge clk25MHz);
    applyStimulus(8'h99);
    waitDrain();
    checkRx("overflow");

    $display("[TB] reset during data bit 3 with bytes queued");
    applyStimulus(8'h00);
    applyStimulus(8'hC3);
    applyStimulus(8'h5A);
    applyStimulus(8'h0F);
    repeat (startQ[0] + 4 * BitClocks + 100 - cyc) @(negedge clk25MHz);
    checkEn = 1'b0;
    #5 reset = 1'b1;
    #1;
    checkOutput("async reset serial_txd", int'(serial_txd), 1);
    checkOutput("async reset idle", int'(idle), 1);
    checkOutput("async reset full", int'(full), 0);
    acceptQ.delete();
    startQ.delete();
    byteQ.delete();
    rxExpQ.delete();
    rxGotQ.delete();
    lastStart = -100000;
    lastDrop  = -1;
    repeat (2) @(negedge clk25MHz);
    reset   = 1'b0;
    checkEn = 1'b1;
    repeat (FrameClocks + 300) @(negedge clk25MHz);
    checkRx("after reset");
    applyStimulus(8'h3C);
    waitDrain();
    checkRx("post-reset 0x3C");

    $display("[TB] random bytes with random spacing");
    r0  = 8'($urandom);
    r1  = 8'($urandom);
    gap = int'($urandom_range(1, 400));
    applyStimulus(r0);
    repeat (gap) @(negedge clk25MHz);
    applyStimulus(r1);
    waitDrain();
    checkRx("random");

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
